dem_tree_scheduler: RTL and testbench



---
 rtl/dem_tree_scheduler.sv | 139 +++++++++++++
 tb/tb_dem_tree_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dem_tree_scheduler.sv
// Time-multiplexed sequencer for a DEM-DAC switching tree: issues every tree node to one shared
// switching datapath, top level first, and stores the returned children in place.
module dem_tree_scheduler #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LEVELS    = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int unsigned LvlW     = (LEVELS > 0) ? $clog2(LEVELS + 1) : 1,
  localparam int unsigned AW       = (LEVELS > 0) ? LEVELS : 1,
  localparam int unsigned NLeaf    = 1 << LEVELS
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [WIDTH-1:0] sample_i,
  input  logic             sample_valid_i,
  output logic             sample_ready_o,
  input  logic             pn_enable_i,
  output logic             node_valid_o,
  output logic [WIDTH-1:0] node_x_o,
  output logic             node_pn_o,
  output logic [LvlW-1:0]  node_level_o,
  output logic [AW-1:0]    node_index_o,
  input  logic             node_done_i,
  input  logic [WIDTH-1:0] node_x1_i,
  input  logic [WIDTH-1:0] node_x2_i,
  output logic [NLeaf-1:0] leaves_o,
  output logic             leaves_valid_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StOutput} state_e;

  localparam logic [LvlW-1:0] LevelsTop = LvlW'(LEVELS);
  localparam logic [LvlW-1:0] LvlOne    = LvlW'(1);
  localparam logic [AW-1:0]   IdxOne    = AW'(1);
  localparam logic [AW:0]     SpanOne   = (AW + 1)'(1);

  state_e           state_q, state_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic [AW-1:0]    index_q, index_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [WIDTH-1:0] buf_q [NLeaf];
  logic [WIDTH-1:0] buf_d [NLeaf];
  logic [NLeaf-1:0] leaves_q, leaves_d;

  logic [AW-1:0] slot, slot_hi, half;
  logic [AW:0]   span;
  logic          idx_last;

  always_comb begin
    // Node (level, index) lives at slot index<<level; its right child sits half a span above.
    slot     = index_q << level_q;
    half     = IdxOne << (level_q - LvlOne);
    slot_hi  = slot + half;
    span     = SpanOne << (LevelsTop - level_q);
    idx_last = (index_q == AW'(span - SpanOne));
  end

  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    index_d        = index_q;
    lfsr_d         = lfsr_q;
    buf_d          = buf_q;
    leaves_d       = leaves_q;
    sample_ready_o = 1'b0;
    node_valid_o   = 1'b0;
    node_x_o       = '0;
    node_pn_o      = 1'b0;
    node_level_o   = '0;
    node_index_o   = '0;
    leaves_valid_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        sample_ready_o = 1'b1;
        if (sample_valid_i) begin
          for (int i = 0; i < NLeaf; i++) buf_d[i] = '0;
          buf_d[0] = sample_i;
          level_d  = LevelsTop;
          index_d  = '0;
          state_d  = (LEVELS == 0) ? StOutput : StIssue;
        end
      end
      StIssue: begin
        node_valid_o = 1'b1;
        node_x_o     = buf_q[slot];
        node_level_o = level_q;
        node_index_o = index_q;
        node_pn_o    = pn_enable_i & lfsr_q[0];
        if (pn_enable_i) begin
          lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
        state_d = StWait;
      end
      StWait: begin
        if (node_done_i) begin
          buf_d[slot]    = node_x1_i;
          buf_d[slot_hi] = node_x2_i;
          if (idx_last) begin
            level_d = level_q - LvlOne;
            index_d = '0;
          end else begin
            index_d = index_q + IdxOne;
          end
          state_d = (level_d == '0) ? StOutput : StIssue;
        end
      end
      StOutput: begin
        leaves_valid_o = 1'b1;
        for (int i = 0; i < NLeaf; i++) leaves_d[i] = buf_q[i][0];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Present the new leaf vector during the strobe itself, then hold it.
    leaves_o = (state_q == StOutput) ? leaves_d : leaves_q;
    busy_o   = (state_q != StIdle);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      level_q  <= '0;
      index_q  <= '0;
      lfsr_q   <= LFSR_SEED;
      leaves_q <= '0;
      for (int i = 0; i < NLeaf; i++) buf_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      index_q  <= index_d;
      lfsr_q   <= lfsr_d;
      leaves_q <= leaves_d;
      for (int i = 0; i < NLeaf; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule

// File: tb/tb_dem_tree_scheduler.sv
// Directed bench for dem_tree_scheduler with a behavioural halving datapath of selectable latency.
module tb_dem_tree_scheduler;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic [7:0] sample_i;
  logic       sample_valid_i;
  logic       sample_ready_o;
  logic       pn_enable_i;
  logic       node_valid_o;
  logic [7:0] node_x_o;
  logic       node_pn_o;
  logic [1:0] node_level_o;
  logic [2:0] node_index_o;
  logic       node_done_i;
  logic [7:0] node_x1_i;
  logic [7:0] node_x2_i;
  logic [7:0] leaves_o;
  logic       leaves_valid_o;
  logic       busy_o;

  dem_tree_scheduler #(
    .WIDTH    (8),
    .LEVELS   (3),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .sample_i      (sample_i),
    .sample_valid_i(sample_valid_i),
    .sample_ready_o(sample_ready_o),
    .pn_enable_i   (pn_enable_i),
    .node_valid_o  (node_valid_o),
    .node_x_o      (node_x_o),
    .node_pn_o     (node_pn_o),
    .node_level_o  (node_level_o),
    .node_index_o  (node_index_o),
    .node_done_i   (node_done_i),
    .node_x1_i     (node_x1_i),
    .node_x2_i     (node_x2_i),
    .leaves_o      (leaves_o),
    .leaves_valid_o(leaves_valid_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Datapath model: x1 = ceil(x/2), x2 = floor(x/2), done dp_lat cycles after the issue strobe.
  int         dp_lat = 1;
  bit         dp_spur = 1'b0;
  bit         dp_rand = 1'b0;
  int         dp_cnt = 0;
  logic [7:0] dp_x = '0;

  initial begin
    node_done_i = 1'b0;
    node_x1_i   = '0;
    node_x2_i   = '0;
    forever begin
      step();
      if (dp_rand) begin
        node_done_i = 1'($urandom);
        node_x1_i   = 8'($urandom);
        node_x2_i   = 8'($urandom);
        dp_cnt      = 0;
      end else begin
        node_done_i = 1'b0;
        if (!reset_ni) dp_cnt = 0;
        if (dp_cnt > 0) begin
          dp_cnt--;
          if (dp_cnt == 0) begin
            node_done_i = 1'b1;
            node_x1_i   = 8'((dp_x + 9'd1) >> 1);
            node_x2_i   = dp_x >> 1;
          end
        end
        if (node_valid_o) begin
          dp_cnt = dp_lat;
          dp_x   = node_x_o;
          if (dp_spur) begin
            node_done_i = 1'b1;
            node_x1_i   = 8'hFF;
            node_x2_i   = 8'hFF;
          end
        end else if (dp_spur && sample_ready_o && reset_ni) begin
          node_done_i = 1'b1;
          node_x1_i   = 8'hFF;
          node_x2_i   = 8'hFF;
        end
      end
    end
  end

  int         nn;
  int         out_cyc;
  int         ready_bad;
  logic [7:0] out_leaves;
  logic [7:0] x_h [16];
  logic [4:0] li_h [16];
  logic       pn_h [16];
  logic [15:0] lfsr_h [16];

  // Runs one conversion from IDLE; cycle 1 is the accept cycle. Stops in the OUTPUT cycle.
  task automatic run_conv(input logic [7:0] s, input bit pn);
    bit prev_issue;
    prev_issue     = 1'b0;
    pn_enable_i    = pn;
    nn             = 0;
    out_cyc        = 0;
    ready_bad      = 0;
    sample_i       = s;
    sample_valid_i = 1'b1;
    step();
    sample_valid_i = 1'b0;
    for (int c = 2; c <= 100 && out_cyc == 0; c++) begin
      if (prev_issue) lfsr_h[nn-1] = dut.lfsr_q;
      prev_issue = 1'b0;
      if (sample_ready_o) ready_bad++;
      if (node_valid_o && nn < 16) begin
        x_h[nn]    = node_x_o;
        li_h[nn]   = {node_level_o, node_index_o};
        pn_h[nn]   = node_pn_o;
        nn++;
        prev_issue = 1'b1;
      end
      if (leaves_valid_o) begin
        out_cyc    = c;
        out_leaves = leaves_o;
      end else begin
        step();
      end
    end
  endtask

  task automatic check_seq(input string tag, input logic [55:0] exp_x);
    logic [34:0] exp_li;
    exp_li = {5'b11_000, 5'b10_000, 5'b10_001, 5'b01_000, 5'b01_001, 5'b01_010, 5'b01_011};
    check_eq({tag, "_nodes"}, nn, 7);
    for (int i = 0; i < 7; i++) begin
      check_eq($sformatf("%s_x%0d", tag, i), x_h[i], exp_x[55-8*i -: 8]);
      check_eq($sformatf("%s_li%0d", tag, i), li_h[i], exp_li[34-5*i -: 5]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_ni       = 1'b0;
    sample_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    step();
  endtask

  initial begin
    int  acc;
    int  lv;
    bit  found;
    sample_i       = '0;
    sample_valid_i = 1'b0;
    pn_enable_i    = 1'b0;

    // Reset held with random inputs
    dp_rand = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      sample_i       = 8'($urandom);
      sample_valid_i = 1'($urandom);
      pn_enable_i    = 1'($urandom);
      #2;
      check_eq("rst_outs", {node_valid_o, node_x_o, node_level_o, node_index_o, node_pn_o,
                            leaves_o, leaves_valid_o, busy_o}, 32'd0);
      check_eq("rst_lfsr", dut.lfsr_q, 16'hACE1);
    end
    dp_rand        = 1'b0;
    sample_valid_i = 1'b0;
    pn_enable_i    = 1'b0;
    @(negedge clk_i);
    reset_ni = 1'b1;
    step();
    check_eq("rst_ready", sample_ready_o, 1'b1);
    check_eq("rst_busy", busy_o, 1'b0);

    // Functional path, L=1, PN off
    run_conv(8'd5, 1'b0);
    check_eq("f5_cycle", out_cyc, 16);
    check_eq("f5_leaves", out_leaves, 8'h57);
    check_eq("f5_ready", ready_bad, 0);
    check_seq("f5", {8'd5, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd1});
    check_eq("f5_pn", {pn_h[0], pn_h[1], pn_h[2], pn_h[3], pn_h[4], pn_h[5], pn_h[6]}, 7'd0);
    check_eq("f5_lfsr_frozen", dut.lfsr_q, 16'hACE1);
    step();
    check_eq("f5_hold", leaves_o, 8'h57);
    check_eq("f5_idle", {busy_o, sample_ready_o}, 2'b01);

    run_conv(8'd13, 1'b0);
    check_eq("f13_leaves", out_leaves, 8'hA8);
    check_seq("f13", {8'd13, 8'd7, 8'd6, 8'd4, 8'd3, 8'd3, 8'd3});
    step();
    run_conv(8'd255, 1'b0);
    check_eq("f255_cycle", out_cyc, 16);
    check_eq("f255_leaves", out_leaves, 8'h80);
    step();

    // LFSR stepping
    do_reset();
    run_conv(8'd5, 1'b1);
    check_eq("pn_bits", {pn_h[0], pn_h[1], pn_h[2]}, 3'b111);
    check_eq("pn_lfsr1", lfsr_h[0], 16'h59C3);
    check_eq("pn_lfsr2", lfsr_h[1], 16'hB387);
    check_eq("pn_leaves", out_leaves, 8'h57);
    step();

    // Datapath latency 3
    dp_lat = 3;
    run_conv(8'd5, 1'b0);
    check_eq("l3_cycle", out_cyc, 30);
    check_eq("l3_leaves", out_leaves, 8'h57);
    dp_lat = 1;
    step();

    // Valid held high, spurious done outside WAIT
    dp_spur        = 1'b1;
    pn_enable_i    = 1'b0;
    sample_i       = 8'd5;
    sample_valid_i = 1'b1;
    acc = 0;
    lv  = 0;
    for (int c = 1; c <= 32; c++) begin
      if (sample_valid_i && sample_ready_o) acc++;
      if (leaves_valid_o) begin
        lv++;
        check_eq($sformatf("hs_leaves_c%0d", c), leaves_o, 8'h57);
      end
      step();
    end
    sample_valid_i = 1'b0;
    dp_spur        = 1'b0;
    check_eq("hs_accepts", acc, 2);
    check_eq("hs_outputs", lv, 2);
    step();

    // Reset during WAIT at level 2
    pn_enable_i    = 1'b1;
    sample_i       = 8'd13;
    sample_valid_i = 1'b1;
    step();
    sample_valid_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (node_valid_o && node_level_o == 2'd2) found = 1'b1;
      else step();
    end
    check_eq("mr_found_lvl2", found, 1'b1);
    step();
    check_eq("mr_in_wait", busy_o, 1'b1);
    reset_ni = 1'b0;
    #1;
    check_eq("mr_idle", {busy_o, sample_ready_o, node_valid_o}, 3'b010);
    check_eq("mr_lfsr", dut.lfsr_q, 16'hACE1);
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    lv = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (leaves_valid_o) lv++;
    end
    check_eq("mr_no_output", lv, 0);
    run_conv(8'd255, 1'b0);
    check_eq("mr_cycle", out_cyc, 16);
    check_eq("mr_leaves", out_leaves, 8'h80);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
